// File: rtl/ram2p_fifo_ctrl_if.sv
// ram2p_fifo_ctrl_if: push/pop stream bundle for ram2p_fifo_ctrl
//  pushValid/pushReady/pushData : write-side valid/ready stream (master drives valid/data)
//  popValid/popReady/popData    : first-word-fall-through read-side stream (slave drives valid/data)
interface ram2p_fifo_ctrl_if #(parameter int DW = 3);
  logic pushValid;
  logic pushReady;
  logic [DW-1:0] pushData;
  logic popValid;
  logic popReady;
  logic [DW-1:0] popData;
  modport master(output pushValid, pushData, popReady, input pushReady, popValid, popData);
  modport slave(input pushValid, pushData, popReady, output pushReady, popValid, popData);
endinterface

// File: rtl/ram2p_fifo_ctrl.sv
// ram2p_fifo_ctrl: stream FIFO controller driving an external two-port RAM with 1-cycle registered read
//  clockCore, resetCoreN : clock and asynchronous active-low reset
//  flush                 : synchronous clear, present only when RAM2P_FIFO_FLUSH_EN is defined
//  io (slave)            : push stream in, FWFT pop stream out
//  level                 : words held in RAM + in-flight read + output buffer
//  ram*                  : write port (enable/address/data) and read port (enable/address, data back next cycle)
module ram2p_fifo_ctrl #(
  parameter int AW = 8,
  parameter int DW = 3
) (
  input  logic clockCore,
  input  logic resetCoreN,
`ifdef RAM2P_FIFO_FLUSH_EN
  input  logic flush,
`endif
  ram2p_fifo_ctrl_if.slave io,
  output logic [AW+1:0] level,
  output logic ramEnableWrite,
  output logic [AW-1:0] ramAddressWrite,
  output logic [DW-1:0] ramWriteData,
  output logic ramEnableRead,
  output logic [AW-1:0] ramAddressRead,
  input  logic [DW-1:0] ramReadData
);
  localparam int DEPTH = 2 ** AW;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] memCount;
  logic inFlight;
  logic [1:0] bufCount;
  logic [DW-1:0] head, skid;
  logic flushNow, pushFire, popFire, rdEn;
`ifdef RAM2P_FIFO_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif
  assign io.pushReady = (memCount != (AW+1)'(DEPTH)) & ~flushNow;
  assign io.popValid = (bufCount != 2'd0) & ~flushNow;
  assign io.popData = head;
  // resetCoreN gating keeps the RAM write port quiet the instant reset asserts
  assign pushFire = io.pushValid & io.pushReady & resetCoreN;
  assign popFire = io.popValid & io.popReady;
  // prefetch only while the buffer plus the word in flight leaves a free slot after this cycle's pop
  assign rdEn = (memCount != '0) & ~flushNow &
                ((3'(bufCount) + 3'(inFlight)) < (3'd2 + 3'(popFire)));
  assign ramEnableWrite = pushFire;
  assign ramAddressWrite = pushFire ? wrPtr : '0;
  assign ramWriteData = pushFire ? io.pushData : '0;
  assign ramEnableRead = rdEn;
  assign ramAddressRead = rdEn ? rdPtr : '0;
  assign level = (AW+2)'(memCount) + (AW+2)'(inFlight) + (AW+2)'(bufCount);
  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      memCount <= '0;
      inFlight <= 1'b0;
      bufCount <= 2'd0;
      head <= '0;
      skid <= '0;
    end else if (flushNow) begin
      wrPtr <= '0;
      rdPtr <= '0;
      memCount <= '0;
      inFlight <= 1'b0;
      bufCount <= 2'd0;
    end else begin
      wrPtr <= pushFire ? wrPtr + 1'b1 : wrPtr;
      rdPtr <= rdEn ? rdPtr + 1'b1 : rdPtr;
      memCount <= memCount + (AW+1)'(pushFire) - (AW+1)'(rdEn);
      inFlight <= rdEn;
      bufCount <= bufCount + 2'(inFlight) - 2'(popFire);
      // returning read data lands in the first free slot after this cycle's pop shift
      if (popFire)
        head <= (inFlight && bufCount == 2'd1) ? ramReadData : skid;
      else if (inFlight && bufCount == 2'd0)
        head <= ramReadData;
      if (inFlight && (popFire ? bufCount == 2'd2 : bufCount != 2'd0))
        skid <= ramReadData;
    end
  end
endmodule
